// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Package     : div_pkg
// Description : Shared types, constants and helper functions for the
//               divider sign-handling / handshake stage.
//               - div_state_e   : control FSM state encoding
//               - DIV_N         : default operand/result width
//               - DIV0_QUOT     : quotient returned on divide-by-zero
//               - SIGNED_MIN    : most negative two's-complement value
//               - twos_neg      : two's-complement negate
//               - abs_if_signed : conditional negate (magnitude / sign fix)
// Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DIV_N = 16;

    // Helper functions work on a fixed wide word; callers zero-extend their
    // N-bit operand and cast the result back to N bits. Because negation is
    // modulo 2^k, the low N bits of the wide result equal the N-bit result.
    localparam int DIV_MAXW = 64;

    localparam logic [DIV_N-1:0] DIV0_QUOT  = '1;
    localparam logic [DIV_N-1:0] SIGNED_MIN = {1'b1, {(DIV_N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIX  = 2'd2,
        RESP = 2'd3
    } div_state_e;

    typedef logic [DIV_MAXW-1:0] div_word_t;

    function automatic div_word_t twos_neg(input div_word_t x);
        return ~x + div_word_t'(1);
    endfunction

    function automatic div_word_t abs_if_signed(input div_word_t x, input logic neg);
        return neg ? twos_neg(x) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sign_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_sign_ctrl
// Description : Sign-handling and valid/ready wrapper around an external
//               unsigned N-bit combinational divider. Operands are turned
//               into magnitudes and held on dv_* for DIV_LAT cycles, the raw
//               result is sampled, sign-corrected (truncating semantics) and
//               presented to writeback. Divide-by-zero and signed overflow
//               bypass the divider entirely.
// Ports       :
//   clk, rst_n                 clock / asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_signed                 1 = two's-complement, 0 = unsigned
//   req_dividend/req_divisor   request operands
//   dv_dividend/dv_divisor     magnitudes driven to the divider
//   dv_quotient/dv_remainder   raw unsigned divider result
//   rsp_valid/rsp_ready        response handshake
//   rsp_quotient/rsp_remainder final result
//   rsp_div_zero/rsp_overflow  exception flags
// Revision    : 1.0  initial release
// ============================================================================
module div_sign_ctrl
    import div_pkg::*;
#(
    parameter int N       = DIV_N,
    parameter int DIV_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_signed,
    input  logic [N-1:0] req_dividend,
    input  logic [N-1:0] req_divisor,
    output logic [N-1:0] dv_dividend,
    output logic [N-1:0] dv_divisor,
    input  logic [N-1:0] dv_quotient,
    input  logic [N-1:0] dv_remainder,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_quotient,
    output logic [N-1:0] rsp_remainder,
    output logic         rsp_div_zero,
    output logic         rsp_overflow
);

    localparam int            CW           = $clog2(DIV_LAT + 1);
    localparam logic [N-1:0]  C_ALL_ONES   = '1;
    localparam logic [N-1:0]  C_SIGNED_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] C_CNT_LOAD   = CW'(DIV_LAT - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dv_dividend_q, dv_dividend_d;
    logic [N-1:0]  dv_divisor_q, dv_divisor_d;
    logic          dvd_neg_q, dvd_neg_d;
    logic          dvs_neg_q, dvs_neg_d;
    logic [N-1:0]  raw_quot_q, raw_quot_d;
    logic [N-1:0]  raw_rem_q, raw_rem_d;
    logic [N-1:0]  rsp_quot_q, rsp_quot_d;
    logic [N-1:0]  rsp_rem_q, rsp_rem_d;
    logic          rsp_dz_q, rsp_dz_d;
    logic          rsp_ov_q, rsp_ov_d;

    // Operand signs only count for signed requests, so the latched flags
    // already encode "negative and signed" and FIX needs no req_signed copy.
    logic          w_dvd_neg;
    logic          w_dvs_neg;
    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;
    logic          w_div_zero;
    logic          w_overflow;
    logic [N-1:0]  w_fix_quot;
    logic [N-1:0]  w_fix_rem;

    assign w_dvd_neg  = req_signed & req_dividend[N-1];
    assign w_dvs_neg  = req_signed & req_divisor[N-1];
    assign w_dvd_mag  = N'(abs_if_signed(DIV_MAXW'(req_dividend), w_dvd_neg));
    assign w_dvs_mag  = N'(abs_if_signed(DIV_MAXW'(req_divisor), w_dvs_neg));
    assign w_div_zero = (req_divisor == '0);
    assign w_overflow = req_signed && (req_dividend == C_SIGNED_MIN)
                                   && (req_divisor == C_ALL_ONES);

    // Truncating division: quotient sign is the XOR of operand signs,
    // remainder takes the sign of the dividend.
    assign w_fix_quot = N'(abs_if_signed(DIV_MAXW'(raw_quot_q), dvd_neg_q ^ dvs_neg_q));
    assign w_fix_rem  = N'(abs_if_signed(DIV_MAXW'(raw_rem_q), dvd_neg_q));

    // ------------------------------------------------------------------
    // State / datapath register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dv_dividend_q <= '0;
            dv_divisor_q  <= '0;
            dvd_neg_q     <= 1'b0;
            dvs_neg_q     <= 1'b0;
            raw_quot_q    <= '0;
            raw_rem_q     <= '0;
            rsp_quot_q    <= '0;
            rsp_rem_q     <= '0;
            rsp_dz_q      <= 1'b0;
            rsp_ov_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dv_dividend_q <= dv_dividend_d;
            dv_divisor_q  <= dv_divisor_d;
            dvd_neg_q     <= dvd_neg_d;
            dvs_neg_q     <= dvs_neg_d;
            raw_quot_q    <= raw_quot_d;
            raw_rem_q     <= raw_rem_d;
            rsp_quot_q    <= rsp_quot_d;
            rsp_rem_q     <= rsp_rem_d;
            rsp_dz_q      <= rsp_dz_d;
            rsp_ov_q      <= rsp_ov_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dv_dividend_d = dv_dividend_q;
        dv_divisor_d  = dv_divisor_q;
        dvd_neg_d     = dvd_neg_q;
        dvs_neg_d     = dvs_neg_q;
        raw_quot_d    = raw_quot_q;
        raw_rem_d     = raw_rem_q;
        rsp_quot_d    = rsp_quot_q;
        rsp_rem_d     = rsp_rem_q;
        rsp_dz_d      = rsp_dz_q;
        rsp_ov_d      = rsp_ov_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    dvd_neg_d = w_dvd_neg;
                    dvs_neg_d = w_dvs_neg;
                    if (w_div_zero) begin
                        // Special paths leave dv_* untouched.
                        rsp_quot_d = C_ALL_ONES;
                        rsp_rem_d  = req_dividend;
                        rsp_dz_d   = 1'b1;
                        rsp_ov_d   = 1'b0;
                        state_d    = RESP;
                    end else if (w_overflow) begin
                        rsp_quot_d = C_SIGNED_MIN;
                        rsp_rem_d  = '0;
                        rsp_dz_d   = 1'b0;
                        rsp_ov_d   = 1'b1;
                        state_d    = RESP;
                    end else begin
                        dv_dividend_d = w_dvd_mag;
                        dv_divisor_d  = w_dvs_mag;
                        cnt_d         = C_CNT_LOAD;
                        state_d       = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    raw_quot_d = dv_quotient;
                    raw_rem_d  = dv_remainder;
                    state_d    = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                rsp_quot_d = w_fix_quot;
                rsp_rem_d  = w_fix_rem;
                rsp_dz_d   = 1'b0;
                rsp_ov_d   = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    assign dv_dividend   = dv_dividend_q;
    assign dv_divisor    = dv_divisor_q;
    assign rsp_quotient  = rsp_quot_q;
    assign rsp_remainder = rsp_rem_q;
    assign rsp_div_zero  = rsp_dz_q;
    assign rsp_overflow  = rsp_ov_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sign_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_sign_ctrl
// Description : Self-checking bench for div_sign_ctrl. Instance A uses
//               DIV_LAT=1, instance B uses DIV_LAT=4. Each instance has a
//               behavioural unsigned divider attached to its dv_* ports.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div_sign_ctrl;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        logic [7:0]  lat;
    } exp_t;

    typedef struct packed {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (DIV_LAT = 1) ----------------
    logic        a_rst_n, a_req_valid, a_req_ready, a_req_signed;
    logic [15:0] a_req_dividend, a_req_divisor;
    logic [15:0] a_dv_dividend, a_dv_divisor, a_dv_quotient, a_dv_remainder;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_div_zero, a_rsp_overflow;
    logic [15:0] a_rsp_quotient, a_rsp_remainder;

    assign a_dv_quotient  = (a_dv_divisor == 16'd0) ? 16'hFFFF : a_dv_dividend / a_dv_divisor;
    assign a_dv_remainder = (a_dv_divisor == 16'd0) ? a_dv_dividend : a_dv_dividend % a_dv_divisor;

    div_sign_ctrl #(.N(16), .DIV_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_signed(a_req_signed),
        .req_dividend(a_req_dividend), .req_divisor(a_req_divisor),
        .dv_dividend(a_dv_dividend), .dv_divisor(a_dv_divisor),
        .dv_quotient(a_dv_quotient), .dv_remainder(a_dv_remainder),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_quotient(a_rsp_quotient), .rsp_remainder(a_rsp_remainder),
        .rsp_div_zero(a_rsp_div_zero), .rsp_overflow(a_rsp_overflow)
    );

    // ---------------- instance B (DIV_LAT = 4) ----------------
    logic        b_rst_n, b_req_valid, b_req_ready, b_req_signed;
    logic [15:0] b_req_dividend, b_req_divisor;
    logic [15:0] b_dv_dividend, b_dv_divisor, b_dv_quotient, b_dv_remainder;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_div_zero, b_rsp_overflow;
    logic [15:0] b_rsp_quotient, b_rsp_remainder;

    assign b_dv_quotient  = (b_dv_divisor == 16'd0) ? 16'hFFFF : b_dv_dividend / b_dv_divisor;
    assign b_dv_remainder = (b_dv_divisor == 16'd0) ? b_dv_dividend : b_dv_dividend % b_dv_divisor;

    div_sign_ctrl #(.N(16), .DIV_LAT(4)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_signed(b_req_signed),
        .req_dividend(b_req_dividend), .req_divisor(b_req_divisor),
        .dv_dividend(b_dv_dividend), .dv_divisor(b_dv_divisor),
        .dv_quotient(b_dv_quotient), .dv_remainder(b_dv_remainder),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_quotient(b_rsp_quotient), .rsp_remainder(b_rsp_remainder),
        .rsp_div_zero(b_rsp_div_zero), .rsp_overflow(b_rsp_overflow)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    // Magnitudes instance A should currently hold on dv_* (bench-side model).
    logic [15:0] exp_dvd = 16'd0;
    logic [15:0] exp_dvs = 16'd0;

    function automatic logic [15:0] mag(input logic s, input logic [15:0] x);
        return (s && x[15]) ? (16'd0 - x) : x;
    endfunction

    // Reference result using native signed division (truncates toward zero).
    function automatic exp_t model(input logic s, input logic [15:0] a, input logic [15:0] b, input int normal_lat);
        exp_t e;
        e = '0;
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.dz = 1'b1; e.lat = 8'd1;
        end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
            e.q = 16'h8000; e.r = 16'd0; e.ov = 1'b1; e.lat = 8'd1;
        end else if (s) begin
            e.q = 16'($signed(a) / $signed(b));
            e.r = 16'($signed(a) % $signed(b));
            e.lat = 8'(normal_lat);
        end else begin
            e.q = a / b; e.r = a % b; e.lat = 8'(normal_lat);
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic s, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] q, input logic [15:0] r,
                                input logic dz, input logic ov);
        vec_t v;
        v.s = s; v.a = a; v.b = b;
        v.e.q = q; v.e.r = r; v.e.dz = dz; v.e.ov = ov;
        v.e.lat = (dz || ov) ? 8'd1 : 8'd3;
        return v;
    endfunction

    // Drive one request into A; returns at the negedge after the accept edge.
    task automatic a_send(input logic s, input logic [15:0] a, input logic [15:0] b, output logic rdy);
        @(negedge clk);
        rdy            = a_req_ready;
        a_req_signed   = s;
        a_req_dividend = a;
        a_req_divisor  = b;
        a_req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_req_valid    = 1'b0;
    endtask

    // Count negedges from the accept edge until rsp_valid, bounded.
    task automatic a_collect(output int lat);
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic a_release(output logic v_after, output logic rdy_after);
        a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rsp_ready = 1'b0;
        v_after     = a_rsp_valid;
        rdy_after   = a_req_ready;
    endtask

    task automatic run_vectors(input string tag, input vec_t tbl[$]);
        logic        rdy, v_after, rdy_after;
        logic [15:0] dvd, dvs;
        int          lat;
        exp_t        e;
        foreach (tbl[i]) begin
            sb.push_back(tbl[i].e);
            if (!tbl[i].e.dz && !tbl[i].e.ov) begin
                exp_dvd = mag(tbl[i].s, tbl[i].a);
                exp_dvs = mag(tbl[i].s, tbl[i].b);
            end
            a_send(tbl[i].s, tbl[i].a, tbl[i].b, rdy);
            dvd = a_dv_dividend;
            dvs = a_dv_divisor;
            a_collect(lat);
            e = sb.pop_front();
            n_vec += 9;
            if (rdy !== 1'b1) begin n_err++; $display("FAIL %s[%0d] req_ready before accept: got %b want 1", tag, i, rdy); end
            if (dvd !== exp_dvd) begin n_err++; $display("FAIL %s[%0d] dv_dividend: got %h want %h", tag, i, dvd, exp_dvd); end
            if (dvs !== exp_dvs) begin n_err++; $display("FAIL %s[%0d] dv_divisor: got %h want %h", tag, i, dvs, exp_dvs); end
            if (lat != int'(e.lat)) begin n_err++; $display("FAIL %s[%0d] latency: got %0d want %0d", tag, i, lat, e.lat); end
            if (a_rsp_quotient !== e.q) begin n_err++; $display("FAIL %s[%0d] quotient: got %h want %h", tag, i, a_rsp_quotient, e.q); end
            if (a_rsp_remainder !== e.r) begin n_err++; $display("FAIL %s[%0d] remainder: got %h want %h", tag, i, a_rsp_remainder, e.r); end
            if (a_rsp_div_zero !== e.dz) begin n_err++; $display("FAIL %s[%0d] div_zero: got %b want %b", tag, i, a_rsp_div_zero, e.dz); end
            if (a_rsp_overflow !== e.ov) begin n_err++; $display("FAIL %s[%0d] overflow: got %b want %b", tag, i, a_rsp_overflow, e.ov); end
            a_release(v_after, rdy_after);
            if (v_after !== 1'b0 || rdy_after !== 1'b1) begin
                n_err++;
                $display("FAIL %s[%0d] after handshake valid/ready: got %b/%b want 0/1", tag, i, v_after, rdy_after);
            end
        end
    endtask

    task automatic test_reset;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_signed = 1'b0; a_req_dividend = '0; a_req_divisor = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_signed = 1'b0; b_req_dividend = '0; b_req_divisor = '0; b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec += 4;
        if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b want 1", a_req_ready); end
        if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset rsp_valid: got %b want 0", a_rsp_valid); end
        if ({a_dv_dividend, a_dv_divisor} !== 32'd0) begin n_err++; $display("FAIL reset dv: got %h%h want 0", a_dv_dividend, a_dv_divisor); end
        if ({a_rsp_quotient, a_rsp_remainder, a_rsp_div_zero, a_rsp_overflow} !== 34'd0) begin
            n_err++; $display("FAIL reset rsp fields: got %h %h %b %b want 0", a_rsp_quotient, a_rsp_remainder, a_rsp_div_zero, a_rsp_overflow);
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        vec_t t[$];
        t.push_back(mk(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0));
        run_vectors("unsigned", t);
    endtask

    task automatic test_sign_matrix;
        vec_t t[$];
        t.push_back(mk(1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0));
        t.push_back(mk(1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0));
        t.push_back(mk(1'b1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0));
        run_vectors("sign_matrix", t);
    endtask

    task automatic test_div_zero;
        vec_t t[$];
        t.push_back(mk(1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0));
        t.push_back(mk(1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0));
        run_vectors("div_zero", t);
    endtask

    task automatic test_overflow;
        vec_t t[$];
        t.push_back(mk(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1));
        t.push_back(mk(1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0));
        t.push_back(mk(1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, 1'b0));
        run_vectors("overflow", t);
    endtask

    task automatic test_random;
        vec_t t[$];
        vec_t v;
        for (int i = 0; i < 10; i++) begin
            v.s = 1'($urandom_range(0, 1));
            v.a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       v.b = 16'($urandom_range(1, 20));
                1:       v.b = 16'hFFFF - 16'($urandom_range(0, 20));
                default: v.b = 16'($urandom_range(1, 65535));
            endcase
            v.e = model(v.s, v.a, v.b, 3);
            t.push_back(v);
        end
        run_vectors("random", t);
    endtask

    task automatic test_backpressure;
        logic        rdy;
        int          lat;
        exp_t        e;
        sb.push_back(model(1'b0, 16'd1000, 16'd3, 3));
        a_send(1'b0, 16'd1000, 16'd3, rdy);
        a_collect(lat);
        e = sb.pop_front();
        n_vec += 2;
        if (lat != int'(e.lat)) begin n_err++; $display("FAIL backpressure latency: got %0d want %0d", lat, e.lat); end
        if (a_rsp_quotient !== e.q || a_rsp_remainder !== e.r) begin
            n_err++; $display("FAIL backpressure result: got %h/%h want %h/%h", a_rsp_quotient, a_rsp_remainder, e.q, e.r);
        end
        for (int i = 0; i < 5; i++) begin
            a_req_valid    = 1'b1;
            a_req_signed   = 1'b1;
            a_req_dividend = 16'($urandom);
            a_req_divisor  = 16'd5;
            @(negedge clk);
            n_vec++;
            if (a_rsp_valid !== 1'b1 || a_req_ready !== 1'b0 || a_rsp_quotient !== e.q
                || a_rsp_remainder !== e.r || a_dv_dividend !== 16'd1000 || a_dv_divisor !== 16'd3) begin
                n_err++;
                $display("FAIL backpressure hold[%0d]: valid=%b ready=%b q=%h r=%h dv=%h/%h want 1 0 %h %h 03e8/0003",
                         i, a_rsp_valid, a_req_ready, a_rsp_quotient, a_rsp_remainder, a_dv_dividend, a_dv_divisor, e.q, e.r);
            end
        end
        // Present the next request while completing the handshake.
        a_req_signed   = 1'b0;
        a_req_dividend = 16'd50;
        a_req_divisor  = 16'd7;
        sb.push_back(model(1'b0, 16'd50, 16'd7, 3));
        a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rsp_ready = 1'b0;
        n_vec++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            n_err++; $display("FAIL backpressure release: valid/ready got %b/%b want 0/1", a_rsp_valid, a_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        exp_dvd = 16'd50;
        exp_dvs = 16'd7;
        n_vec++;
        if (a_dv_dividend !== exp_dvd || a_dv_divisor !== exp_dvs) begin
            n_err++; $display("FAIL backpressure next accept dv: got %h/%h want %h/%h", a_dv_dividend, a_dv_divisor, exp_dvd, exp_dvs);
        end
        a_collect(lat);
        e = sb.pop_front();
        n_vec++;
        if (lat != int'(e.lat) || a_rsp_quotient !== e.q || a_rsp_remainder !== e.r) begin
            n_err++; $display("FAIL backpressure next result: lat=%0d q=%h r=%h want %0d %h %h", lat, a_rsp_quotient, a_rsp_remainder, e.lat, e.q, e.r);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rsp_ready = 1'b0;
    endtask

    task automatic test_reset_latency;
        int   seen;
        int   lat;
        exp_t e;
        // Start an operation on B and kill it with reset while in WAIT.
        @(negedge clk);
        b_req_signed = 1'b0; b_req_dividend = 16'd1000; b_req_divisor = 16'd10; b_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        n_vec++;
        if (b_dv_dividend !== 16'd1000 || b_dv_divisor !== 16'd10) begin
            n_err++; $display("FAIL reset_mid dv before reset: got %h/%h want 03e8/000a", b_dv_dividend, b_dv_divisor);
        end
        @(negedge clk);
        b_rst_n = 1'b0;
        #1;
        n_vec++;
        if (b_dv_dividend !== 16'd0 || b_dv_divisor !== 16'd0 || b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1
            || b_rsp_quotient !== 16'd0 || b_rsp_remainder !== 16'd0) begin
            n_err++; $display("FAIL reset_mid outputs: dv=%h/%h valid=%b ready=%b q=%h r=%h want 0 0 0 1 0 0",
                              b_dv_dividend, b_dv_divisor, b_rsp_valid, b_req_ready, b_rsp_quotient, b_rsp_remainder);
        end
        @(negedge clk);
        b_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b_rsp_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL reset_mid stray response cycles: got %0d want 0", seen); end
        // Fresh request after reset: 4-cycle divider wait gives 6-cycle latency.
        sb.push_back(model(1'b0, 16'd50000, 16'd300, 6));
        b_req_signed = 1'b0; b_req_dividend = 16'd50000; b_req_divisor = 16'd300; b_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        lat = 1;
        while (!b_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        n_vec += 3;
        if (lat != int'(e.lat)) begin n_err++; $display("FAIL lat4 latency: got %0d want %0d", lat, e.lat); end
        if (b_rsp_quotient !== e.q || b_rsp_remainder !== e.r) begin
            n_err++; $display("FAIL lat4 result: got %0d/%0d want %0d/%0d", b_rsp_quotient, b_rsp_remainder, e.q, e.r);
        end
        if (b_rsp_div_zero !== 1'b0 || b_rsp_overflow !== 1'b0) begin
            n_err++; $display("FAIL lat4 flags: got %b/%b want 0/0", b_rsp_div_zero, b_rsp_overflow);
        end
        b_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_sign_matrix();
        test_div_zero();
        test_overflow();
        test_random();
        test_backpressure();
        test_reset_latency();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
